fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the 16-bit 5-stage core. Owns the PC,

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_pc_sel.sv | 25 ++
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect source
// encodings, fetch FSM state codes and the default NOP instruction word.
package fetch_pkg;

  // Redirect source selector driven by decode-stage PC control
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_RETURN = 2'd3;

  // Fetch FSM state codes
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_DRAIN = 2'd3;

  localparam logic [15:0] DEFAULT_NOP = 16'h0000;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selector: picks the sequential or redirect target from pcSrc.
module fetch_pc_sel
  import fetch_pkg::*;
(
  input  logic [1:0]  pcSrc,
  input  logic [15:0] pc_plus1,
  input  logic [15:0] jumpTarget,
  input  logic [15:0] branchTarget,
  input  logic [15:0] returnAddr,
  output logic [15:0] next_pc
);

  // Pure mux; all targets are already full 16-bit word addresses
  always_comb begin
    next_pc = pc_plus1;
    case (pcSrc)
      PC_SEQ:    next_pc = pc_plus1;
      PC_JUMP:   next_pc = jumpTarget;
      PC_BRANCH: next_pc = branchTarget;
      PC_RETURN: next_pc = returnAddr;
      default:   next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit core.
// Owns the PC, fetches over a req/ack handshake, parks a word that arrives
// during a hazard stall in a one-entry skid register, and drains an unacked
// request after a redirect so the memory never sees a changing address.
// Optional feature: define FETCH_PERF_CNT_EN to add saturating performance
// counters fetchCnt, stallCnt and killCnt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        kill,
  input  logic [1:0]  pcSrc,
  input  logic [15:0] jumpTarget,
  input  logic [15:0] branchTarget,
  input  logic [15:0] returnAddr,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic        imemAck,
  input  logic [15:0] imemData,
  output logic [15:0] ifInstr,
  output logic [15:0] ifPcPlus1,
  output logic        ifValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetchCnt,
  output logic [15:0] stallCnt,
  output logic [15:0] killCnt
`endif
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_plus1;
  logic [15:0]  next_pc;
  logic [15:0]  drain_addr;
  logic         redirect;

  // IF/ID register
  logic [15:0]  instr_p1;
  logic [15:0]  pc_plus1_p1;
  logic         vld_p1;

  // Skid entry for a word acked while decode is stalled
  logic [15:0]  skid_instr;
  logic [15:0]  skid_pc_plus1;
  logic         skid_vld;

  assign pc_plus1 = pc + 16'd1;
  // Stall wins over kill: the control instruction stays in ID and retries
  assign redirect = kill && !stall;

  fetch_pc_sel u_pc_sel (
    .pcSrc        (pcSrc),
    .pc_plus1     (pc_plus1),
    .jumpTarget   (jumpTarget),
    .branchTarget (branchTarget),
    .returnAddr   (returnAddr),
    .next_pc      (next_pc)
  );

  // Request is live in FETCH and DRAIN; DRAIN keeps presenting the abandoned address
  always_comb begin
    imemReq  = (state == ST_FETCH) || (state == ST_DRAIN);
    imemAddr = (state == ST_DRAIN) ? drain_addr : pc;
  end

  assign ifInstr   = instr_p1;
  assign ifPcPlus1 = pc_plus1_p1;
  assign ifValid   = vld_p1;

  // Control path: FSM, PC and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr_p1    <= NOP_INSTR;
      pc_plus1_p1 <= 16'h0000;
      vld_p1      <= 1'b0;
      skid_vld    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          if (redirect) begin
            pc       <= next_pc;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (redirect) begin
            pc       <= next_pc;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
            // An acked word is simply dropped; an unacked one must be drained
            state    <= imemAck ? ST_FETCH : ST_DRAIN;
          end else if (imemAck && !stall) begin
            instr_p1    <= imemData;
            pc_plus1_p1 <= pc_plus1;
            vld_p1      <= 1'b1;
            pc          <= pc_plus1;
          end else if (imemAck) begin
            skid_vld <= 1'b1;
            pc       <= pc_plus1;
            state    <= ST_HOLD;
          end else if (!stall) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc       <= next_pc;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
            state    <= ST_FETCH;
          end else if (!stall) begin
            instr_p1    <= skid_instr;
            pc_plus1_p1 <= skid_pc_plus1;
            vld_p1      <= skid_vld;
            skid_vld    <= 1'b0;
            state       <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (redirect) begin
            pc <= next_pc;
          end
          if (!stall) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end
          if (imemAck) begin
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data path: skid payload and the address held during a drain
  always_ff @(posedge clk) begin
    if (state == ST_FETCH && imemAck && stall) begin
      skid_instr    <= imemData;
      skid_pc_plus1 <= pc_plus1;
    end
    if (state == ST_FETCH && redirect && !imemAck) begin
      drain_addr <= pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating event counters: accepted fetches, stall cycles, applied redirects
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchCnt <= 16'h0000;
      stallCnt <= 16'h0000;
      killCnt  <= 16'h0000;
    end else begin
      if (state == ST_FETCH && imemAck && !redirect) fetchCnt <= sat_inc(fetchCnt);
      if (stall)                                     stallCnt <= sat_inc(stallCnt);
      if (redirect)                                  killCnt  <= sat_inc(killCnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID contents.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        kill;
  logic [1:0]  pcSrc;
  logic [15:0] jumpTarget;
  logic [15:0] branchTarget;
  logic [15:0] returnAddr;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemData;
  logic [15:0] ifInstr;
  logic [15:0] ifPcPlus1;
  logic        ifValid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetchCnt;
  logic [15:0] stallCnt;
  logic [15:0] killCnt;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] sb[$];

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .kill         (kill),
    .pcSrc        (pcSrc),
    .jumpTarget   (jumpTarget),
    .branchTarget (branchTarget),
    .returnAddr   (returnAddr),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .ifInstr      (ifInstr),
    .ifPcPlus1    (ifPcPlus1),
    .ifValid      (ifValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetchCnt     (fetchCnt),
    .stallCnt     (stallCnt),
    .killCnt      (killCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Pop one scoreboard entry and compare it against the IF/ID register
  task automatic check_out(input string tag);
    logic [31:0] e;
    total++;
    assert (sb.size() != 0) passed++;
    else $error("FAIL %s scoreboard empty, ifInstr=%h", tag, ifInstr);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_vld"}, ifValid, 1);
      chk({tag, "_instr"}, ifInstr, e[31:16]);
      chk({tag, "_pcp1"}, ifPcPlus1, e[15:0]);
    end
  endtask

  // One zero-wait fetch at the expected address, result checked one cycle later
  task automatic fetch_ok(input logic [15:0] a);
    logic [15:0] p1;
    p1 = a + 16'd1;
    @(negedge clk);
    chk("fetch_req", imemReq, 1);
    chk("fetch_addr", imemAddr, a);
    stall = 1'b0; kill = 1'b0;
    imemAck = 1'b1; imemData = mem(a);
    sb.push_back({mem(a), p1});
    @(posedge clk); #1;
    imemAck = 1'b0;
    check_out("fetch");
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; kill = 1'b0; pcSrc = 2'd0;
    jumpTarget = '0; branchTarget = '0; returnAddr = '0;
    imemAck = 1'b0; imemData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imemReq, 0);
    chk("rst_vld", ifValid, 0);
    chk("rst_instr", ifInstr, 16'h0000);
    chk("rst_pcp1", ifPcPlus1, 16'h0000);

    // Leave reset: one IDLE cycle without a request
    @(negedge clk); rst_n = 1'b1;
    chk("idle_req", imemReq, 0);
    @(posedge clk); #1;

    // Zero-wait streaming
    for (int i = 0; i < 4; i++) fetch_ok(16'(i));

    // Stall for 3 cycles with an ack in the first one
    @(negedge clk);
    chk("stall_addr", imemAddr, 16'h0004);
    stall = 1'b1; imemAck = 1'b1; imemData = mem(16'h0004);
    sb.push_back({mem(16'h0004), 16'h0005});
    @(posedge clk); #1;
    imemAck = 1'b0;
    chk("hold_req", imemReq, 0);
    chk("hold_instr", ifInstr, mem(16'h0003));
    chk("hold_pcp1", ifPcPlus1, 16'h0004);
    @(negedge clk); @(posedge clk); #1;
    chk("hold2_req", imemReq, 0);
    chk("hold2_instr", ifInstr, mem(16'h0003));
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1;
    check_out("skid");
    fetch_ok(16'h0005);

    // Missing ack without stall bubbles IF/ID and keeps the request stable
    @(negedge clk);
    imemAck = 1'b0;
    @(posedge clk); #1;
    chk("bubble_vld", ifValid, 0);
    chk("bubble_instr", ifInstr, 16'h0000);
    chk("bubble_req", imemReq, 1);
    chk("bubble_addr", imemAddr, 16'h0006);

    // Branch redirect with the request still pending: drain old address
    @(negedge clk);
    kill = 1'b1; pcSrc = 2'd2; branchTarget = 16'h0040;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_vld", ifValid, 0);
    chk("drain_req", imemReq, 1);
    chk("drain_addr", imemAddr, 16'h0006);
    @(negedge clk); @(posedge clk); #1;
    chk("drain2_addr", imemAddr, 16'h0006);
    @(negedge clk);
    imemAck = 1'b1; imemData = 16'hDEAD;
    @(posedge clk); #1;
    imemAck = 1'b0;
    chk("drain_discard_vld", ifValid, 0);
    chk("drain_discard_instr", ifInstr, 16'h0000);
    fetch_ok(16'h0040);

    // Kill together with stall: nothing moves; kill honoured once stall drops
    @(negedge clk);
    chk("ks_addr", imemAddr, 16'h0041);
    stall = 1'b1; kill = 1'b1; pcSrc = 2'd1; jumpTarget = 16'h0100;
    @(posedge clk); #1;
    chk("ks_instr", ifInstr, mem(16'h0040));
    chk("ks_pcp1", ifPcPlus1, 16'h0041);
    chk("ks_vld", ifValid, 1);
    chk("ks_addr_held", imemAddr, 16'h0041);
    @(negedge clk);
    stall = 1'b0; imemAck = 1'b1; imemData = mem(16'h0041);
    @(posedge clk); #1;
    kill = 1'b0; imemAck = 1'b0;
    chk("jmp_vld", ifValid, 0);
    chk("jmp_instr", ifInstr, 16'h0000);
    fetch_ok(16'h0100);

    // Return to 16'hFFFF then wrap to 0
    @(negedge clk);
    kill = 1'b1; pcSrc = 2'd3; returnAddr = 16'hFFFF; imemAck = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; imemAck = 1'b0;
    fetch_ok(16'hFFFF);
    fetch_ok(16'h0000);

    // Reset in the middle of a drain
    @(negedge clk);
    kill = 1'b1; pcSrc = 2'd1; jumpTarget = 16'h0200;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("rd_req", imemReq, 1);
    chk("rd_addr", imemAddr, 16'h0001);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("rd_rst_req", imemReq, 0);
    chk("rd_rst_vld", ifValid, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rd_fetchCnt", fetchCnt, 16'h0000);
    chk("rd_stallCnt", stallCnt, 16'h0000);
    chk("rd_killCnt", killCnt, 16'h0000);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fetch_ok(16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
